// File: rtl/pll_drp_resp_if.sv
// DRP bus between a requester and the PLL DRP responder.
//   DEN   request strobe, one cycle      DWE   write enable, qualified by DEN
//   DADDR register address (5 bits)      DI    write data (16 bits)
//   DO    read data, zero unless DRDY    DRDY  completion strobe, one cycle
interface pll_drp_resp_if;
  logic        DEN;
  logic        DWE;
  logic [4:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (
    output DEN, DWE, DADDR, DI,
    input  DO, DRDY
  );

  modport slave (
    input  DEN, DWE, DADDR, DI,
    output DO, DRDY
  );
endinterface

// File: rtl/pll_drp_resp.sv
// Behavioural stand-in for a PLL dynamic reconfiguration port.
// A 32 x 16-bit register bank answers DRP reads and writes after a fixed latency, and an
// emulated lock detector raises LOCKED after RST_PLL has been low for LOCK_CYC cycles.
// Ports:
//   CLK     DRP clock, rising edge
//   RSTXO   asynchronous active-low reset of all state, including the register bank
//   drp     DRP bus (slave side)
//   RST_PLL PLL reset request, active-high
//   LOCKED  emulated lock indication
//   ERR     sticky protocol error: DEN while busy, or a write while the PLL is running
//   WR_CNT  accepted writes, saturating at 255
module pll_drp_resp #(
  parameter int unsigned RDY_LAT  = 3,   // 1..15
  parameter int unsigned LOCK_CYC = 64   // 2..1023
) (
  input  logic               CLK,
  input  logic               RSTXO,
  pll_drp_resp_if.slave      drp,
  input  logic               RST_PLL,
  output logic               LOCKED,
  output logic               ERR,
  output logic [7:0]         WR_CNT
);

  localparam logic [3:0] LatLoad  = 4'(RDY_LAT - 1);
  // Count is cleared on the HOLD->COUNT edge, which already counts as one low cycle.
  localparam logic [9:0] LockLast = 10'(LOCK_CYC - 2);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} tx_state_e;
  typedef enum logic [1:0] {StHold, StCount, StLock} lk_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [4:0]  addr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [15:0] regs_q [32];
  logic        err_q, err_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic        accept;
  logic        reg_we;

  lk_state_e   lk_state_q, lk_state_d;
  logic [9:0]  lk_cnt_q, lk_cnt_d;

  // Transaction FSM
  always_comb begin
    tx_state_d = tx_state_q;
    lat_cnt_d  = lat_cnt_q;
    err_d      = err_q;
    wr_cnt_d   = wr_cnt_q;
    accept     = 1'b0;
    reg_we     = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        if (drp.DEN) begin
          accept     = 1'b1;
          lat_cnt_d  = LatLoad;
          tx_state_d = (RDY_LAT == 1) ? StResp : StBusy;
          if (drp.DWE && !RST_PLL) err_d = 1'b1;
        end
      end
      StBusy: begin
        // Counter holds RDY_LAT-1 in the first BUSY cycle; leaving when it reaches 1 puts
        // RESP exactly RDY_LAT cycles after the DEN cycle.
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) tx_state_d = StResp;
      end
      StResp: begin
        tx_state_d = StIdle;
        if (we_q) begin
          reg_we   = 1'b1;
          wr_cnt_d = (wr_cnt_q != 8'hFF) ? wr_cnt_q + 8'd1 : wr_cnt_q;
        end
      end
      default: tx_state_d = StIdle;
    endcase
    if (drp.DEN && (tx_state_q != StIdle)) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      tx_state_q <= StIdle;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      lat_cnt_q  <= lat_cnt_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
      if (accept) begin
        addr_q  <= drp.DADDR;
        we_q    <= drp.DWE;
        wdata_q <= drp.DWE ? drp.DI : 16'h0000;
      end
      if (reg_we) regs_q[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    drp.DRDY = (tx_state_q == StResp);
    drp.DO   = (drp.DRDY && !we_q) ? regs_q[addr_q] : 16'h0000;
  end

  assign ERR    = err_q;
  assign WR_CNT = wr_cnt_q;

  // Lock FSM, independent of DRP traffic
  always_comb begin
    lk_state_d = lk_state_q;
    lk_cnt_d   = lk_cnt_q;
    unique case (lk_state_q)
      StHold: begin
        if (!RST_PLL) begin
          lk_state_d = StCount;
          lk_cnt_d   = '0;
        end
      end
      StCount: begin
        if (RST_PLL) begin
          lk_state_d = StHold;
        end else if (lk_cnt_q == LockLast) begin
          lk_state_d = StLock;
        end else begin
          lk_cnt_d = lk_cnt_q + 10'd1;
        end
      end
      StLock: begin
        if (RST_PLL) lk_state_d = StHold;
      end
      default: lk_state_d = StHold;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      lk_state_q <= StHold;
      lk_cnt_q   <= '0;
    end else begin
      lk_state_q <= lk_state_d;
      lk_cnt_q   <= lk_cnt_d;
    end
  end

  assign LOCKED = (lk_state_q == StLock);

endmodule

// File: tb/tb_pll_drp_resp.sv
// Scoreboard bench for pll_drp_resp: randomized and directed DRP traffic against a
// transaction-level model, plus latency checks on RDY_LAT=1 and RDY_LAT=15 builds.
module tb_pll_drp_resp;
  localparam int unsigned RDY_LAT  = 3;
  localparam int unsigned LOCK_CYC = 64;

  logic       CLK = 1'b0;
  logic       RSTXO;
  logic       RST_PLL;
  logic       LOCKED, ERR;
  logic [7:0] WR_CNT;
  logic       l1_locked, l1_err, l15_locked, l15_err;
  logic [7:0] l1_wr, l15_wr;

  pll_drp_resp_if drp ();
  pll_drp_resp_if drp1 ();
  pll_drp_resp_if drp15 ();

  pll_drp_resp #(.RDY_LAT(RDY_LAT), .LOCK_CYC(LOCK_CYC)) dut (
    .CLK(CLK), .RSTXO(RSTXO), .drp(drp), .RST_PLL(RST_PLL),
    .LOCKED(LOCKED), .ERR(ERR), .WR_CNT(WR_CNT)
  );
  pll_drp_resp #(.RDY_LAT(1), .LOCK_CYC(LOCK_CYC)) u_lat1 (
    .CLK(CLK), .RSTXO(RSTXO), .drp(drp1), .RST_PLL(1'b1),
    .LOCKED(l1_locked), .ERR(l1_err), .WR_CNT(l1_wr)
  );
  pll_drp_resp #(.RDY_LAT(15), .LOCK_CYC(LOCK_CYC)) u_lat15 (
    .CLK(CLK), .RSTXO(RSTXO), .drp(drp15), .RST_PLL(1'b1),
    .LOCKED(l15_locked), .ERR(l15_err), .WR_CNT(l15_wr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: bank contents, busy window, sticky error, write count, lock run length
  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [32];
  int          free_at;
  bit          model_err;
  int          model_wr;
  int          run;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
    sb.delete();
    free_at   = 0;
    model_err = 1'b0;
    model_wr  = 0;
  endfunction

  // Consecutive clock edges that saw RST_PLL low; lock is due once it reaches LOCK_CYC
  always @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) run <= 0;
    else if (RST_PLL) run <= 0;
    else if (run < LOCK_CYC) run <= run + 1;
  end

  // Monitor
  bit   exp_drdy;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (RSTXO) begin
      exp_drdy = (sb.size() > 0) && (sb[0].due == cyc);
      chk("drdy", {31'd0, drp.DRDY}, {31'd0, exp_drdy});
      if (exp_drdy) begin
        mon_e = sb.pop_front();
        if (drp.DRDY) chk("do_resp", {16'd0, drp.DO}, {16'd0, mon_e.data});
      end
      if (!drp.DRDY) chk("do_idle", {16'd0, drp.DO}, 32'd0);
      chk("locked", {31'd0, LOCKED}, {31'd0, run >= LOCK_CYC});
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask

  task automatic drp_op(input bit wr, input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    drp.DEN   = 1'b1;
    drp.DWE   = wr;
    drp.DADDR = a;
    drp.DI    = d;
    if (cyc >= free_at) begin
      free_at = cyc + RDY_LAT + 1;
      e.data  = wr ? 16'h0000 : model_mem[a];
      e.due   = cyc + RDY_LAT;
      sb.push_back(e);
      if (wr) begin
        model_mem[a] = d;
        if (!RST_PLL) model_err = 1'b1;
        if (model_wr < 255) model_wr++;
      end
    end else begin
      model_err = 1'b1;
    end
    @(posedge CLK);
    #1;
    drp.DEN = 1'b0;
    drp.DWE = 1'b0;
  endtask

  task automatic drain();
    idle(RDY_LAT + 2);
  endtask

  task automatic status(input string tag);
    chk({tag, "_err"}, {31'd0, ERR}, {31'd0, model_err});
    chk({tag, "_wr_cnt"}, {24'd0, WR_CNT}, model_wr);
  endtask

  int first1, first15, n1, n15;
  bit bad1, bad15;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RSTXO   = 1'b0;
    RST_PLL = 1'b1;
    drp.DEN = 1'b0; drp.DWE = 1'b0; drp.DADDR = '0; drp.DI = '0;
    drp1.DEN = 1'b0; drp1.DWE = 1'b0; drp1.DADDR = '0; drp1.DI = '0;
    drp15.DEN = 1'b0; drp15.DWE = 1'b0; drp15.DADDR = '0; drp15.DI = '0;
    model_reset();
    #23;
    chk("rst_drdy", {31'd0, drp.DRDY}, 32'd0);
    chk("rst_do", {16'd0, drp.DO}, 32'd0);
    chk("rst_locked", {31'd0, LOCKED}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_wr_cnt", {24'd0, WR_CNT}, 32'd0);
    @(posedge CLK);
    #1;
    RSTXO = 1'b1;
    idle(2);

    // Write/readback with PLL held in reset
    drp_op(1'b1, 5'd5, 16'hA5C3);
    drain();
    drp_op(1'b0, 5'd5, 16'h0000);
    drain();
    status("wr_rd");

    // Overlapping DEN during an in-flight read
    drp_op(1'b1, 5'd3, 16'h1234);
    drain();
    drp_op(1'b0, 5'd3, 16'h0000);
    drp_op(1'b0, 5'd7, 16'h0000);
    drain();
    status("overlap");

    // Randomized traffic with occasional PLL reset toggling
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(7) == 0) RST_PLL = ~RST_PLL;
      drp_op(1'($urandom_range(1)), 5'($urandom_range(31)), 16'($urandom));
      idle($urandom_range(4));
    end
    drain();
    status("random");

    // Lock timing with an interrupting pulse
    RST_PLL = 1'b1;
    idle(3);
    RST_PLL = 1'b0;
    idle(30);
    RST_PLL = 1'b1;
    idle(1);
    RST_PLL = 1'b0;
    idle(LOCK_CYC + 6);
    chk("locked_after_pulse", {31'd0, LOCKED}, 32'd1);

    // Write while PLL running: performed, flags error, lock untouched
    drp_op(1'b1, 5'd31, 16'h0001);
    drain();
    drp_op(1'b0, 5'd31, 16'h0000);
    drain();
    status("wr_running");
    chk("locked_after_write", {31'd0, LOCKED}, 32'd1);

    // Reset one cycle after DEN of a write
    RST_PLL = 1'b1;
    idle(2);
    drp_op(1'b1, 5'd9, 16'hFFFF);
    RSTXO = 1'b0;
    model_reset();
    idle(2);
    RSTXO = 1'b1;
    idle(RDY_LAT + 2);
    status("mid_rst");
    drp_op(1'b0, 5'd9, 16'h0000);
    drain();

    // Write counter saturation
    for (int i = 0; i < 256; i++) begin
      drp_op(1'b1, 5'($urandom_range(31)), 16'($urandom));
      idle(RDY_LAT);
    end
    drain();
    status("sat");
    chk("wr_cnt_sat", {24'd0, WR_CNT}, 32'd255);

    // Latency sweep on the RDY_LAT=1 and RDY_LAT=15 builds
    first1 = -1; first15 = -1; n1 = 0; n15 = 0; bad1 = 1'b0; bad15 = 1'b0;
    drp1.DEN = 1'b1;
    drp15.DEN = 1'b1;
    begin
      int c0;
      c0 = cyc;
      @(posedge CLK);
      #1;
      drp1.DEN = 1'b0;
      drp15.DEN = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge CLK);
        if (drp1.DRDY) begin
          if (first1 < 0) first1 = cyc - c0;
          n1++;
          if (drp1.DO != 16'h0000) bad1 = 1'b1;
        end
        if (drp15.DRDY) begin
          if (first15 < 0) first15 = cyc - c0;
          n15++;
          if (drp15.DO != 16'h0000) bad15 = 1'b1;
        end
      end
    end
    chk("lat1_delay", first1, 32'd1);
    chk("lat1_width", n1, 32'd1);
    chk("lat1_do", {31'd0, bad1}, 32'd0);
    chk("lat15_delay", first15, 32'd15);
    chk("lat15_width", n15, 32'd1);
    chk("lat15_do", {31'd0, bad15}, 32'd0);

    idle(2);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
